sap_cpu_gen2: RTL and testbench



---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/sap_microcode.sv | 119 +++++++++++
 rtl/sap_cpu_gen2.sv | 129 ++++++++++++
 tb/tb_sap_cpu_gen2.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, stage encodings and control-word bit indices
//
// Purpose: definitions used by the sequencer (sap_microcode) and the datapath
// (sap_cpu_gen2). Opcodes are kept at their 4-bit encodings and are widened
// to INSTR_SIZE by the consumers.
// Ports: none (package).

package cpu_pkg;

  // Opcode encodings (4-bit). Anything not listed executes as NOP.
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    T3 = 3'd2,
    T4 = 3'd3,
    T5 = 3'd4
  } stage_t;

  // Control word bit indices. *o bits select the bus source, *i bits load
  // a register from the bus.
  localparam int CTRL_W = 15;
  localparam int MI  = 0;   // MAR in
  localparam int RO  = 1;   // RAM out
  localparam int RI  = 2;   // RAM in
  localparam int II  = 3;   // IR in
  localparam int IO  = 4;   // IR operand out
  localparam int AI  = 5;   // A in
  localparam int AO  = 6;   // A out
  localparam int BI  = 7;   // B in
  localparam int SU  = 8;   // ALU subtract
  localparam int EO  = 9;   // ALU out (also latches flags)
  localparam int OI  = 10;  // output register in
  localparam int CE  = 11;  // PC increment
  localparam int CO  = 12;  // PC out
  localparam int J   = 13;  // PC load (jump)
  localparam int HLT = 14;  // halt

  typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/sap_microcode.sv
// rtl/sap_microcode.sv - combinational control-word and next-stage decoder
//
// Purpose: maps (stage, opcode, flags) to the control word for this cycle
// and the stage to enter next.
// Ports:
//   stage      in  current stage T1..T5
//   opcode     in  IR opcode field, INSTR_SIZE bits
//   c_flag     in  carry flag
//   z_flag     in  zero flag
//   ctrl       out control word (bit indices in cpu_pkg)
//   next_stage out stage after this cycle

module sap_microcode
  import cpu_pkg::*;
#(
  parameter int INSTR_SIZE = 4
) (
  input  stage_t                  stage,
  input  logic [INSTR_SIZE-1:0]   opcode,
  input  logic                    c_flag,
  input  logic                    z_flag,
  output ctrl_t                   ctrl,
  output stage_t                  next_stage
);

  localparam logic [INSTR_SIZE-1:0] W_LDA = INSTR_SIZE'(OP_LDA);
  localparam logic [INSTR_SIZE-1:0] W_ADD = INSTR_SIZE'(OP_ADD);
  localparam logic [INSTR_SIZE-1:0] W_SUB = INSTR_SIZE'(OP_SUB);
  localparam logic [INSTR_SIZE-1:0] W_STA = INSTR_SIZE'(OP_STA);
  localparam logic [INSTR_SIZE-1:0] W_LDI = INSTR_SIZE'(OP_LDI);
  localparam logic [INSTR_SIZE-1:0] W_JMP = INSTR_SIZE'(OP_JMP);
  localparam logic [INSTR_SIZE-1:0] W_JC  = INSTR_SIZE'(OP_JC);
  localparam logic [INSTR_SIZE-1:0] W_JZ  = INSTR_SIZE'(OP_JZ);
  localparam logic [INSTR_SIZE-1:0] W_OUT = INSTR_SIZE'(OP_OUT);
  localparam logic [INSTR_SIZE-1:0] W_HLT = INSTR_SIZE'(OP_HLT);

  always_comb begin
    ctrl       = '0;
    next_stage = T1;
    case (stage)
      T1: begin
        ctrl[CO]   = 1'b1;
        ctrl[MI]   = 1'b1;
        next_stage = T2;
      end
      T2: begin
        ctrl[RO]   = 1'b1;
        ctrl[II]   = 1'b1;
        ctrl[CE]   = 1'b1;
        next_stage = T3;
      end
      T3: begin
        case (opcode)
          W_LDA, W_ADD, W_SUB, W_STA: begin
            ctrl[IO]   = 1'b1;
            ctrl[MI]   = 1'b1;
            next_stage = T4;
          end
          W_LDI: begin
            ctrl[IO] = 1'b1;
            ctrl[AI] = 1'b1;
          end
          W_JMP: begin
            ctrl[IO] = 1'b1;
            ctrl[J]  = 1'b1;
          end
          W_JC: begin
            ctrl[IO] = 1'b1;
            ctrl[J]  = c_flag;
          end
          W_JZ: begin
            ctrl[IO] = 1'b1;
            ctrl[J]  = z_flag;
          end
          W_OUT: begin
            ctrl[AO] = 1'b1;
            ctrl[OI] = 1'b1;
          end
          W_HLT: begin
            // The datapath freezes on halted, so T3 is simply held.
            ctrl[HLT]  = 1'b1;
            next_stage = T3;
          end
          default: ;
        endcase
      end
      T4: begin
        case (opcode)
          W_LDA: begin
            ctrl[RO] = 1'b1;
            ctrl[AI] = 1'b1;
          end
          W_ADD: begin
            ctrl[RO]   = 1'b1;
            ctrl[BI]   = 1'b1;
            next_stage = T5;
          end
          W_SUB: begin
            ctrl[RO]   = 1'b1;
            ctrl[BI]   = 1'b1;
            next_stage = T5;
          end
          W_STA: begin
            ctrl[AO] = 1'b1;
            ctrl[RI] = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        ctrl[EO] = 1'b1;
        ctrl[AI] = 1'b1;
        ctrl[SU] = (opcode == W_SUB);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sap_cpu_gen2.sv
// rtl/sap_cpu_gen2.sv - accumulator CPU top: registers, RAM and bus datapath
//
// Purpose: SAP-style CPU with PC, MAR, IR, A, B, C/Z flags, output register
// and a single-port RAM that the host can preload.
// Ports:
//   clk        in  clock, all state on posedge
//   rst        in  synchronous active-high reset
//   load_en    in  host RAM write strobe, freezes the core while high
//   load_addr  in  host write address
//   load_data  in  host write data
//   out_data   out output register (OUT instruction)
//   out_valid  out one-cycle pulse when out_data updates
//   halted     out sticky halt indicator
//   pc_dbg     out program counter

module sap_cpu_gen2
  import cpu_pkg::*;
#(
  parameter  int WIDTH         = 8,
  parameter  int INSTR_SIZE    = 4,
  parameter  int OUT_WIDTH     = 8,
  localparam int ADDRESS_WIDTH = WIDTH - INSTR_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic [ADDRESS_WIDTH-1:0] load_addr,
  input  logic [WIDTH-1:0]         load_data,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     out_valid,
  output logic                     halted,
  output logic [ADDRESS_WIDTH-1:0] pc_dbg
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [WIDTH-1:0]         mem [0:DEPTH-1];
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] mar;
  logic [WIDTH-1:0]         ir;
  logic [WIDTH-1:0]         a_reg;
  logic [WIDTH-1:0]         b_reg;
  logic                     c_flag;
  logic                     z_flag;
  stage_t                   stage;

  ctrl_t                    ctrl;
  stage_t                   next_stage;
  logic [WIDTH-1:0]         mem_rd;
  logic [WIDTH-1:0]         bus;
  logic [WIDTH:0]           alu_sum;
  logic                     run;

  assign pc_dbg = pc;
  assign mem_rd = mem[mar];
  assign run    = !load_en && !halted;

  sap_microcode #(.INSTR_SIZE(INSTR_SIZE)) u_microcode (
    .stage      (stage),
    .opcode     (ir[WIDTH-1:ADDRESS_WIDTH]),
    .c_flag     (c_flag),
    .z_flag     (z_flag),
    .ctrl       (ctrl),
    .next_stage (next_stage)
  );

  // Subtract is A + ~B + 1, so the carry out reads as "no borrow".
  always_comb begin
    alu_sum = {1'b0, a_reg} + {1'b0, (ctrl[SU] ? ~b_reg : b_reg)} + (WIDTH + 1)'(ctrl[SU]);
  end

  always_comb begin
    bus = '0;
    if (ctrl[CO])      bus = WIDTH'(pc);
    else if (ctrl[IO]) bus = WIDTH'(ir[ADDRESS_WIDTH-1:0]);
    else if (ctrl[RO]) bus = mem_rd;
    else if (ctrl[AO]) bus = a_reg;
    else if (ctrl[EO]) bus = alu_sum[WIDTH-1:0];
  end

  // Host writes go through even during reset; core writes never do.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (!rst && !halted && ctrl[RI]) begin
      mem[mar] <= bus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage     <= T1;
      pc        <= '0;
      mar       <= '0;
      ir        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (run) begin
        stage <= next_stage;
        if (ctrl[MI]) mar   <= bus[ADDRESS_WIDTH-1:0];
        if (ctrl[II]) ir    <= bus;
        if (ctrl[AI]) a_reg <= bus;
        if (ctrl[BI]) b_reg <= bus;
        if (ctrl[J]) begin
          pc <= bus[ADDRESS_WIDTH-1:0];
        end else if (ctrl[CE]) begin
          pc <= pc + ADDRESS_WIDTH'(1);
        end
        if (ctrl[EO]) begin
          c_flag <= alu_sum[WIDTH];
          z_flag <= (alu_sum[WIDTH-1:0] == '0);
        end
        if (ctrl[OI]) begin
          out_data  <= bus[OUT_WIDTH-1:0];
          out_valid <= 1'b1;
        end
        if (ctrl[HLT]) halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sap_cpu_gen2.sv
// tb/tb_sap_cpu_gen2.sv - self-checking bench for sap_cpu_gen2

module tb_sap_cpu_gen2;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;
  logic [3:0] pc_dbg;

  sap_cpu_gen2 #(.WIDTH(8), .INSTR_SIZE(4), .OUT_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .halted    (halted),
    .pc_dbg    (pc_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] cur_img [16];
  int ep [200];
  int ev [200];
  int eh [200];
  int eo [200];

  typedef struct {
    int cycles;
    int exp_pulses;
    int exp_last;
    int exp_pc;
    int exp_halt;
  } vec_t;

  localparam int NV = 9;
  vec_t       vecs [NV];
  logic [7:0] vec_img [NV][16];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level reference: walks the program one instruction at a
  // time and lays out the observable per-cycle values from cycle counts.
  task automatic build_trace(input int n);
    int mm [16];
    int pc, a, c, z, od, cyc, op, opr, len, npc, nod;
    bit is_out;
    for (int i = 0; i < 16; i++) mm[i] = cur_img[i];
    pc = 0; a = 0; c = 0; z = 0; od = 0; cyc = 1;
    while (cyc <= n) begin
      op  = mm[pc] / 16;
      opr = mm[pc] % 16;
      npc = (pc + 1) % 16;
      len = 3;
      is_out = 0;
      nod = od;
      if (op == 15) begin
        for (int k = cyc; k <= n; k++) begin
          ep[k] = (k == cyc) ? pc : npc;
          ev[k] = 0;
          eh[k] = (k >= cyc + 2) ? 1 : 0;
          eo[k] = od;
        end
        cyc = n + 1;
      end else begin
        case (op)
          1: begin len = 4; a = mm[opr]; end
          2: begin len = 5; c = (a + mm[opr] > 255) ? 1 : 0; a = (a + mm[opr]) % 256; z = (a == 0) ? 1 : 0; end
          3: begin len = 5; c = (a >= mm[opr]) ? 1 : 0; a = (a - mm[opr] + 256) % 256; z = (a == 0) ? 1 : 0; end
          4: begin len = 4; mm[opr] = a; end
          5: a = opr;
          6: npc = opr;
          7: if (c != 0) npc = opr;
          8: if (z != 0) npc = opr;
          14: begin is_out = 1; nod = a; end
          default: ;
        endcase
        for (int k = 0; k < len; k++) begin
          if (cyc + k <= n) begin
            ep[cyc+k] = (k == 0) ? pc : ((k == len - 1) ? npc : (pc + 1) % 16);
            ev[cyc+k] = (is_out && k == 2) ? 1 : 0;
            eh[cyc+k] = 0;
            eo[cyc+k] = (is_out && k == 2) ? nod : od;
          end
        end
        od = nod;
        pc = npc;
        cyc += len;
      end
    end
  endtask

  // Loads cur_img with rst held high, then checks the reset state.
  task automatic load_img();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_en   = 1'b1;
      load_addr = 4'(i);
      load_data = cur_img[i];
      tick();
    end
    load_en = 1'b0;
    tick();
    chk("reset_pc", int'(pc_dbg), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_halted", int'(halted), 0);
    chk("reset_out_data", int'(out_data), 0);
  endtask

  task automatic cmp_cycle(input string tag, input int k, input int idx);
    chk($sformatf("%s_pc@%0d", tag, k), int'(pc_dbg), ep[idx]);
    chk($sformatf("%s_valid@%0d", tag, k), int'(out_valid), ev[idx]);
    chk($sformatf("%s_halted@%0d", tag, k), int'(halted), eh[idx]);
    chk($sformatf("%s_out_data@%0d", tag, k), int'(out_data), eo[idx]);
  endtask

  task automatic run_prog(input string tag, input int n, output int pulses, output int last);
    pulses = 0;
    last = 0;
    build_trace(n);
    load_img();
    rst = 1'b0;
    for (int k = 1; k <= n; k++) begin
      tick();
      cmp_cycle(tag, k, k);
      if (out_valid === 1'b1) begin
        pulses++;
        last = int'(out_data);
      end
    end
  endtask

  task automatic set_img(input int v);
    for (int i = 0; i < 16; i++) cur_img[i] = vec_img[v][i];
  endtask

  initial begin
    int pulses, last;
    rst = 1'b1;
    load_en = 1'b0;
    load_addr = '0;
    load_data = '0;
    repeat (2) tick();

    vec_img[0] = '{8'h1E, 8'h2F, 8'hE0, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd28, 8'd14};
    vecs[0]    = '{40, 1, 42, 4, 1};
    vec_img[1] = '{8'h1E, 8'h3F, 8'h86, 8'hE0, 8'hF0, 8'h00, 8'h59, 8'hE0, 8'hF0, 0, 0, 0, 0, 0, 8'd5, 8'd5};
    vecs[1]    = '{40, 1, 9, 9, 1};
    vec_img[2] = '{8'h1E, 8'h2F, 8'h75, 8'hF0, 8'hF0, 8'hE0, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 8'd200, 8'd100};
    vecs[2]    = '{40, 1, 44, 7, 1};
    vec_img[3] = '{8'h1E, 8'h2F, 8'h75, 8'hF0, 8'hF0, 8'hE0, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 8'd200, 8'd10};
    vecs[3]    = '{40, 0, 0, 4, 1};
    vec_img[4] = '{8'h57, 8'h4D, 8'h50, 8'h8A, 8'h1D, 8'hE0, 8'hF0, 0, 0, 0, 8'hF0, 0, 0, 0, 0, 0};
    vecs[4]    = '{40, 1, 7, 7, 1};
    vec_img[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5]    = '{48, 0, 0, 0, 0};
    vec_img[6] = '{8'h53, 8'h9F, 8'hCF, 8'hE0, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]    = '{40, 1, 3, 5, 1};
    vec_img[7] = '{8'h1E, 8'h3F, 8'h75, 8'hE0, 8'hF0, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd3, 8'd5};
    vecs[7]    = '{40, 1, 254, 5, 1};
    vec_img[8] = '{8'h51, 8'hE0, 8'h2F, 8'hE0, 8'h67, 8'hF0, 8'hF0, 8'hE0, 8'hF0, 0, 0, 0, 0, 0, 0, 8'd1};
    vecs[8]    = '{40, 3, 2, 9, 1};

    for (int v = 0; v < NV; v++) begin
      set_img(v);
      run_prog($sformatf("vec%0d", v), vecs[v].cycles, pulses, last);
      chk($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
      chk($sformatf("vec%0d_last_out", v), last, vecs[v].exp_last);
      chk($sformatf("vec%0d_final_pc", v), int'(pc_dbg), vecs[v].exp_pc);
      chk($sformatf("vec%0d_halted", v), int'(halted), vecs[v].exp_halt);
    end

    // Reset during T4 of ADD: everything clears and fetch restarts at 0.
    set_img(0);
    build_trace(30);
    load_img();
    rst = 1'b0;
    repeat (7) tick();
    chk("pre_reset_pc", int'(pc_dbg), 2);
    rst = 1'b1;
    tick();
    chk("midrst_pc", int'(pc_dbg), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_halted", int'(halted), 0);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      cmp_cycle("restart", k, k);
    end

    // load_en held for three cycles across T3 of LDA.
    build_trace(30);
    load_img();
    rst = 1'b0;
    for (int p = 1; p <= 30; p++) begin
      if (p >= 3 && p <= 5) begin
        load_en   = 1'b1;
        load_addr = 4'd12;
        load_data = 8'h55;
      end else begin
        load_en = 1'b0;
      end
      tick();
      if (p >= 3 && p <= 5) begin
        chk($sformatf("freeze_pc@%0d", p), int'(pc_dbg), 1);
        chk($sformatf("freeze_valid@%0d", p), int'(out_valid), 0);
        chk($sformatf("freeze_halted@%0d", p), int'(halted), 0);
      end else begin
        cmp_cycle("freeze", p, (p < 3) ? p : p - 3);
      end
      if (p == 15) begin
        chk("freeze_out_at15", int'(out_valid), 1);
        chk("freeze_out_data15", int'(out_data), 42);
      end
      if (p == 17) chk("freeze_not_halted17", int'(halted), 0);
      if (p == 18) chk("freeze_halted18", int'(halted), 1);
    end

    // Host write while halted keeps the halt.
    load_en   = 1'b1;
    load_addr = 4'd11;
    load_data = 8'hAA;
    tick();
    tick();
    load_en = 1'b0;
    chk("halted_load_halted", int'(halted), 1);
    chk("halted_load_pc", int'(pc_dbg), 4);
    chk("halted_load_valid", int'(out_valid), 0);
    tick();
    chk("halted_after_load", int'(halted), 1);

    // Random programs against the instruction-level reference.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 16; i++) cur_img[i] = 8'($urandom_range(0, 255));
      run_prog($sformatf("rnd%0d", r), 120, pulses, last);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
